// File: rtl/ibex_qed_commit_checker.sv
// SQED commit checker: shadows the RF write port, counts original/duplicate commits, scans pairs when counts match.
// Optional sticky error reporting is enabled with `define IBEX_QED_CHECK_STICKY_EN.
module ibex_qed_commit_checker #(
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned DupOffset = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                check_en_i,
  input  logic                rf_we_wb_i,
  input  logic [4:0]          rf_waddr_wb_i,
  input  logic [31:0]         rf_wdata_wb_i,
  input  logic                qed_vld_out_final_i,
  output logic                check_busy_o,
  output logic                check_done_o,
  output logic                check_fail_o,
  output logic [3:0]          fail_idx_o,
  output logic [CntWidth-1:0] num_orig_o,
  output logic [CntWidth-1:0] num_dup_o,
  output logic                qed_error_o
);

  localparam logic [4:0] DupOff = 5'(DupOffset);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_e;

  state_e      state;
  logic [31:0] shadow [32];
  logic [3:0]  idx;
  logic [3:0]  first_idx;
  logic        fail_lat;
  logic        changed;

  logic        orig_wr;
  logic        dup_wr;
  logic        counted;
  logic        start;
  logic        mismatch;
  logic        fail_next;
  logic [3:0]  idx_result;

  // x0 and x16 fall outside both ranges and are never counted.
  assign orig_wr = rf_we_wb_i & qed_vld_out_final_i &
                   (rf_waddr_wb_i != 5'd0) & (rf_waddr_wb_i < DupOff);
  assign dup_wr  = rf_we_wb_i & qed_vld_out_final_i & (rf_waddr_wb_i > DupOff);
  assign counted = orig_wr | dup_wr;

  assign start = check_en_i & (num_orig_o == num_dup_o) & (num_orig_o != '0) &
                 ~counted & changed;

  assign mismatch   = shadow[{1'b0, idx}] != shadow[{1'b0, idx} + DupOff];
  assign fail_next  = fail_lat | mismatch;
  assign idx_result = fail_lat ? first_idx : (mismatch ? idx : 4'd0);

  assign check_busy_o = (state == SCAN);

  // NOTE: the shadow RF is reset like any other flop so a scan right after reset compares known zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else if (rf_we_wb_i && (rf_waddr_wb_i != 5'd0)) begin
      shadow[rf_waddr_wb_i] <= rf_wdata_wb_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_orig_o <= '0;
      num_dup_o  <= '0;
    end else if (orig_wr) begin
      num_orig_o <= num_orig_o + CntWidth'(1);
    end else if (dup_wr) begin
      num_dup_o <= num_dup_o + CntWidth'(1);
    end
  end

`ifdef IBEX_QED_CHECK_STICKY_EN
  logic qed_error;
  assign qed_error_o = qed_error;
`else
  assign qed_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      idx          <= 4'd0;
      first_idx    <= 4'd0;
      fail_lat     <= 1'b0;
      changed      <= 1'b0;
      check_done_o <= 1'b0;
      check_fail_o <= 1'b0;
      fail_idx_o   <= 4'd0;
`ifdef IBEX_QED_CHECK_STICKY_EN
      qed_error    <= 1'b0;
`endif
    end else begin
      check_done_o <= 1'b0;

      // Any counted write re-arms the checker; entering SCAN disarms it.
      if (counted) begin
        changed <= 1'b1;
      end else if (state == IDLE && start) begin
        changed <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            idx       <= 4'd1;
            fail_lat  <= 1'b0;
            first_idx <= 4'd0;
          end
        end

        SCAN: begin
          if (counted) begin
            state    <= IDLE;
            fail_lat <= 1'b0;
          end else begin
            if (mismatch && !fail_lat) begin
              fail_lat  <= 1'b1;
              first_idx <= idx;
            end
            if (idx == 4'd15) begin
              state        <= REPORT;
              check_done_o <= 1'b1;
              check_fail_o <= fail_next;
`ifdef IBEX_QED_CHECK_STICKY_EN
              // The first failing report's index is frozen until reset.
              if (!qed_error) fail_idx_o <= idx_result;
              qed_error <= qed_error | fail_next;
`else
              fail_idx_o <= idx_result;
`endif
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        REPORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_qed_commit_checker.sv
// Scoreboard bench for ibex_qed_commit_checker: default-width unit plus a CntWidth=2 unit for wrap behaviour.
module tb_ibex_qed_commit_checker;

  logic        clk;
  logic        rst_ni;

  logic        check_en   [2];
  logic        rf_we      [2];
  logic [4:0]  rf_waddr   [2];
  logic [31:0] rf_wdata   [2];
  logic        qed_vld    [2];
  logic        busy       [2];
  logic        done       [2];
  logic        fail       [2];
  logic [3:0]  fail_idx   [2];
  logic        qed_error  [2];
  logic [15:0] num_orig0, num_dup0;
  logic [1:0]  num_orig1, num_dup1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

`ifdef IBEX_QED_CHECK_STICKY_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  typedef struct {
    logic       fail;
    logic [3:0] idx;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic       st_err [2];
  logic [3:0] st_idx [2];

  ibex_qed_commit_checker dut0 (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .check_en_i         (check_en[0]),
    .rf_we_wb_i         (rf_we[0]),
    .rf_waddr_wb_i      (rf_waddr[0]),
    .rf_wdata_wb_i      (rf_wdata[0]),
    .qed_vld_out_final_i(qed_vld[0]),
    .check_busy_o       (busy[0]),
    .check_done_o       (done[0]),
    .check_fail_o       (fail[0]),
    .fail_idx_o         (fail_idx[0]),
    .num_orig_o         (num_orig0),
    .num_dup_o          (num_dup0),
    .qed_error_o        (qed_error[0])
  );

  ibex_qed_commit_checker #(.CntWidth(2)) dut1 (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .check_en_i         (check_en[1]),
    .rf_we_wb_i         (rf_we[1]),
    .rf_waddr_wb_i      (rf_waddr[1]),
    .rf_wdata_wb_i      (rf_wdata[1]),
    .qed_vld_out_final_i(qed_vld[1]),
    .check_busy_o       (busy[1]),
    .check_done_o       (done[1]),
    .check_fail_o       (fail[1]),
    .fail_idx_o         (fail_idx[1]),
    .num_orig_o         (num_orig1),
    .num_dup_o          (num_dup1),
    .qed_error_o        (qed_error[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One write per call, issued at a falling edge and sampled at the next rising edge.
  task automatic wr(input int u, input logic [4:0] a, input logic [31:0] d, input logic v);
    @(negedge clk);
    for (int k = 0; k < 2; k++) rf_we[k] = 1'b0;
    rf_we[u]    = 1'b1;
    rf_waddr[u] = a;
    rf_wdata[u] = d;
    qed_vld[u]  = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) rf_we[k] = 1'b0;
    end
  endtask

  // Called in the same step as the equalising write: the report is due 17 cycles later.
  task automatic push(input int u, input logic f, input logic [3:0] i);
    exp_t e;
    e.fail = f;
    e.idx  = i;
    e.cyc  = cyc + 17;
    if (Sticky) begin
      if (st_err[u]) e.idx = st_idx[u];
      else if (f) begin
        st_err[u] = 1'b1;
        st_idx[u] = i;
      end
      e.err = st_err[u];
    end else begin
      e.err = 1'b0;
    end
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_ni && done[0]) begin
      if (q0.size() == 0) check("u0_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("u0_done_cycle", cyc, e.cyc);
        check("u0_fail", fail[0], e.fail);
        check("u0_fail_idx", fail_idx[0], e.idx);
        check("u0_qed_error", qed_error[0], e.err);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_ni && done[1]) begin
      if (q1.size() == 0) check("u1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("u1_done_cycle", cyc, e.cyc);
        check("u1_fail", fail[1], e.fail);
        check("u1_fail_idx", fail_idx[1], e.idx);
        check("u1_qed_error", qed_error[1], e.err);
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_en[k] = 1'b1;
      rf_we[k]    = 1'b0;
      rf_waddr[k] = '0;
      rf_wdata[k] = '0;
      qed_vld[k]  = 1'b0;
      st_err[k]   = 1'b0;
      st_idx[k]   = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_fail", fail[0], 1'b0);
    check("rst_idx", fail_idx[0], 4'd0);
    check("rst_orig", num_orig0, 16'd0);
    check("rst_dup", num_dup0, 16'd0);
    check("rst_err", qed_error[0], 1'b0);
    rst_ni = 1'b1;
    idle(5);
    check("zero_count_no_start", busy[0], 1'b0);

    // Matching pair passes; dropping check_en mid-scan must not abort
    wr(0, 5'd5, 32'h1234, 1'b1);
    wr(0, 5'd21, 32'h1234, 1'b1);
    push(0, 1'b0, 4'd0);
    idle(2);
    check("scan_busy", busy[0], 1'b1);
    check_en[0] = 1'b0;
    idle(3);
    check_en[0] = 1'b1;
    idle(20);
    check("pass_orig", num_orig0, 16'd1);
    check("pass_dup", num_dup0, 16'd1);

    // Two mismatching pairs: lowest index reported
    wr(0, 5'd3, 32'hA, 1'b1);
    wr(0, 5'd19, 32'hB, 1'b1);
    wr(0, 5'd7, 32'h1, 1'b1);
    wr(0, 5'd23, 32'h2, 1'b1);
    push(0, 1'b1, 4'd3);
    idle(20);
    check("fail_orig", num_orig0, 16'd3);
    check("fail_dup", num_dup0, 16'd3);

    // Repair both pairs; later passing report
    wr(0, 5'd3, 32'hB, 1'b1);
    wr(0, 5'd19, 32'hB, 1'b1);
    wr(0, 5'd7, 32'h2, 1'b1);
    wr(0, 5'd23, 32'h2, 1'b1);
    push(0, 1'b0, 4'd0);
    idle(20);

    // Counted write on the 5th SCAN cycle aborts
    wr(0, 5'd11, 32'h5, 1'b1);
    wr(0, 5'd27, 32'h5, 1'b1);
    idle(5);
    wr(0, 5'd9, 32'h99, 1'b1);
    check("abort_pre_busy", busy[0], 1'b1);
    idle(1);
    check("abort_idle", busy[0], 1'b0);
    idle(25);
    check("abort_orig", num_orig0, 16'd7);
    check("abort_dup", num_dup0, 16'd6);
    wr(0, 5'd25, 32'h99, 1'b1);
    push(0, 1'b0, 4'd0);
    idle(20);
    check("retrig_dup", num_dup0, 16'd7);

    // Uncounted writes: x0, x16, and x4 without qed valid
    wr(0, 5'd0, 32'hFF, 1'b1);
    wr(0, 5'd16, 32'h55, 1'b1);
    wr(0, 5'd4, 32'h44, 1'b0);
    idle(20);
    check("uncounted_orig", num_orig0, 16'd7);
    check("uncounted_dup", num_dup0, 16'd7);
    wr(0, 5'd20, 32'h44, 1'b1);
    wr(0, 5'd1, 32'h0, 1'b1);
    push(0, 1'b0, 4'd0);
    idle(20);
    check("shadow_orig", num_orig0, 16'd8);

    // Narrow counters wrap to 0/0 without starting, then a fifth pair triggers
    for (int i = 0; i < 4; i++) begin
      wr(1, 5'd1, 32'(i), 1'b1);
      wr(1, 5'd17, 32'(i), 1'b1);
    end
    idle(20);
    check("wrap_orig", 32'(num_orig1), 32'd0);
    check("wrap_dup", 32'(num_dup1), 32'd0);
    check("wrap_no_busy", busy[1], 1'b0);
    wr(1, 5'd2, 32'h7, 1'b1);
    wr(1, 5'd18, 32'h7, 1'b1);
    push(1, 1'b0, 4'd0);
    idle(20);
    check("wrap5_orig", 32'(num_orig1), 32'd1);
    check("wrap5_dup", 32'(num_dup1), 32'd1);

    // Reset in the middle of a scan: no report, everything cleared
    wr(0, 5'd12, 32'h1, 1'b1);
    wr(0, 5'd28, 32'h1, 1'b1);
    idle(2);
    check("midrst_busy", busy[0], 1'b1);
    idle(3);
    rst_ni = 1'b0;
    #1;
    check("midrst_idle", busy[0], 1'b0);
    check("midrst_orig", num_orig0, 16'd0);
    check("midrst_done", done[0], 1'b0);
    check("midrst_err", qed_error[0], 1'b0);
    for (int k = 0; k < 2; k++) begin
      st_err[k] = 1'b0;
      st_idx[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    idle(25);

    check("u0_pending_reports", q0.size(), 32'd0);
    check("u1_pending_reports", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
